imem_fetch_controller: RTL and testbench

//  Owns the 64x16 instruction memory port. In LOAD mode it assembles 16-bit words

---
 rtl/imem_fetch_controller.sv | 189 ++++++++++++++++++
 tb/tb_imem_fetch_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_controller.sv
// Instruction memory front end: button-driven program loader (LOAD) and PC/fetch/issue sequencer (RUN).
// Optional feature macro IMEM_CLEAR_EN adds a clear_prog input that empties the program while in LOAD.
module imem_fetch_controller #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic              button,
   input  logic [7:0]        instruction,
   input  logic              run,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              halt,
   input  logic              instr_ready,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef IMEM_CLEAR_EN
   input  logic              clear_prog,
`endif
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [DATA_W-1:0] instr_out,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W:0]   prog_len,
   output logic              load_full,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_LOAD  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_ISSUE = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

   state_t            state_q, state_n;
   logic [1:0]        phase_q, phase_n;
   logic              btn_q;
   logic [5:0]        hold_hi_q, hold_hi_n;
   logic [5:0]        hold_mid_q, hold_mid_n;
   logic [ADDR_W-1:0] pc_q, pc_n;
   logic [ADDR_W:0]   len_q, len_n;
   logic              we_q, we_n;
   logic [ADDR_W-1:0] waddr_q, waddr_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic [DATA_W-1:0] instr_q, instr_n;
   logic              valid_q, valid_n;

   logic              edge_det;
   logic              handshake;
   logic [ADDR_W:0]   next_pc;
   logic              unused_bits;

   // instr_out/instr_valid is a valid/ready source: once instr_valid rises, instr_out and
   // instr_valid hold until an enabled cycle with instr_ready high, which is the transfer.
   assign edge_det    = button & ~btn_q;
   assign handshake   = valid_q & instr_ready;
   assign next_pc     = branch_taken ? {1'b0, branch_target} : ({1'b0, pc_q} + ONE);
   assign unused_bits = ^instruction[7:6];

   always_comb begin
      state_n    = state_q;
      phase_n    = phase_q;
      hold_hi_n  = hold_hi_q;
      hold_mid_n = hold_mid_q;
      pc_n       = pc_q;
      len_n      = len_q;
      we_n       = 1'b0;
      waddr_n    = waddr_q;
      wdata_n    = wdata_q;
      instr_n    = instr_q;
      valid_n    = valid_q;

      case (state_q)
         S_LOAD: begin
`ifdef IMEM_CLEAR_EN
            if (clear_prog) begin
               len_n   = '0;
               phase_n = 2'd0;
            end else
`endif
            if (run) begin
               // An empty program cannot run; buttons are ignored either way.
               if (len_q != '0) begin
                  pc_n    = '0;
                  phase_n = 2'd0;
                  state_n = S_FETCH;
               end
            end else if (edge_det && (len_q != DEPTH)) begin
               case (phase_q)
                  2'd0: begin
                     hold_hi_n = instruction[5:0];
                     phase_n   = 2'd1;
                  end
                  2'd1: begin
                     hold_mid_n = instruction[5:0];
                     phase_n    = 2'd2;
                  end
                  default: begin
                     we_n    = 1'b1;
                     waddr_n = len_q[ADDR_W-1:0];
                     wdata_n = {hold_hi_q, hold_mid_q, instruction[3:0]};
                     len_n   = len_q + ONE;
                     phase_n = 2'd0;
                  end
               endcase
            end
         end
         S_FETCH: state_n = S_WAIT;
         S_WAIT: begin
            instr_n = mem_rdata;
            valid_n = 1'b1;
            state_n = S_ISSUE;
         end
         S_ISSUE: begin
            if (handshake) begin
               valid_n = 1'b0;
               // next_pc carries one extra bit so running off the end halts instead of wrapping.
               if (halt || (next_pc >= len_q)) begin
                  state_n = S_HALT;
               end else begin
                  pc_n    = next_pc[ADDR_W-1:0];
                  state_n = S_FETCH;
               end
            end
         end
         S_HALT:  state_n = S_HALT;
         default: state_n = S_LOAD;
      endcase

      if ((state_q != S_LOAD) && !run) begin
         state_n = S_LOAD;
         valid_n = 1'b0;
         pc_n    = '0;
         phase_n = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_LOAD;
         phase_q    <= 2'd0;
         btn_q      <= 1'b0;
         hold_hi_q  <= '0;
         hold_mid_q <= '0;
         pc_q       <= '0;
         len_q      <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
      end else if (clk_enable) begin
         state_q    <= state_n;
         phase_q    <= phase_n;
         btn_q      <= button;
         hold_hi_q  <= hold_hi_n;
         hold_mid_q <= hold_mid_n;
         pc_q       <= pc_n;
         len_q      <= len_n;
         we_q       <= we_n;
         waddr_q    <= waddr_n;
         wdata_q    <= wdata_n;
         instr_q    <= instr_n;
         valid_q    <= valid_n;
      end
   end

   // The write pulse register holds through disabled cycles, so gate it to write exactly once.
   assign mem_we      = we_q & clk_enable;
   assign mem_waddr   = waddr_q;
   assign mem_wdata   = wdata_q;
   assign mem_raddr   = pc_q;
   assign instr_out   = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign prog_len    = len_q;
   assign load_full   = (len_q == DEPTH);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Bench for imem_fetch_controller: bench-side 64x16 memory, program/run reference model,
// and a negedge monitor that scoreboards memory writes and issued instructions.
module tb_imem_fetch_controller;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 64;
   localparam int W      = ADDR_W + DATA_W;
   localparam int MAXD   = 80;

   logic              clk = 1'b0;
   logic              reset, clk_enable, button, run, branch_taken, halt, instr_ready;
   logic [7:0]        instruction;
   logic [ADDR_W-1:0] branch_target;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_we, instr_valid, load_full;
   logic [ADDR_W-1:0] mem_waddr, mem_raddr, pc;
   logic [DATA_W-1:0] mem_wdata, instr_out;
   logic [ADDR_W:0]   prog_len;
   logic [2:0]        dbg_state;
`ifdef IMEM_CLEAR_EN
   logic              clear_prog = 1'b0;
`endif

   imem_fetch_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .button(button),
      .instruction(instruction), .run(run), .branch_taken(branch_taken),
      .branch_target(branch_target), .halt(halt), .instr_ready(instr_ready),
      .mem_rdata(mem_rdata),
`ifdef IMEM_CLEAR_EN
      .clear_prog(clear_prog),
`endif
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_raddr(mem_raddr), .instr_out(instr_out), .instr_valid(instr_valid),
      .pc(pc), .prog_len(prog_len), .load_full(load_full), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Synchronous memory: read data appears one enabled cycle after the address.
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (clk_enable) mem_rdata <= mem[mem_raddr];
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_wr_q[$];
   logic [W-1:0] exp_ix_q[$];

   logic [DATA_W-1:0] prog_model [DEPTH];
   int                len_m = 0;
   bit                dec_halt [MAXD];
   bit                dec_br   [MAXD];
   logic [ADDR_W-1:0] dec_tgt  [MAXD];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         if (exp_wr_q.size() == 0) check("unexpected_write", 32'({mem_waddr, mem_wdata}), 32'hffff_ffff);
         else check("mem_write", 32'({mem_waddr, mem_wdata}), 32'(exp_wr_q.pop_front()));
      end
      if (clk_enable && instr_valid && instr_ready) begin
         if (exp_ix_q.size() == 0) check("unexpected_issue", 32'({pc, instr_out}), 32'hffff_ffff);
         else check("issue_pc_instr", 32'({pc, instr_out}), 32'(exp_ix_q.pop_front()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold button high until one enabled edge sees it, then low until one enabled edge sees that.
   task automatic press(input logic [7:0] v, input bit rnd);
      bit seen;
      int tries;
      instruction = v;
      for (int lvl = 1; lvl >= 0; lvl--) begin
         button = 1'(lvl);
         tries  = 0;
         do begin
            seen = clk_enable;
            step();
            tries++;
            clk_enable = (rnd && tries < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
         end while (!seen);
      end
   endtask

   task automatic load_word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input bit rnd);
      logic [DATA_W-1:0] word;
      word = {a[5:0], b[5:0], c[3:0]};
      if (len_m < DEPTH) begin
         exp_wr_q.push_back({ADDR_W'(len_m), word});
         prog_model[len_m] = word;
         len_m++;
      end
      press(a, rnd);
      press(b, rnd);
      press(c, rnd);
      clk_enable = 1'b1;
      repeat (2) step();
      check("prog_len_after_load", 32'(prog_len), 32'(len_m));
   endtask

   task automatic load_random(input bit rnd);
      load_word(8'($urandom), 8'($urandom), 8'($urandom), rnd);
   endtask

   task automatic clear_dec();
      for (int i = 0; i < MAXD; i++) begin
         dec_halt[i] = 1'b0;
         dec_br[i]   = 1'b0;
         dec_tgt[i]  = '0;
      end
      dec_halt[MAXD-1] = 1'b1;
   endtask

   task automatic gen_dec();
      int hi;
      hi = (len_m + 1 > DEPTH - 1) ? DEPTH - 1 : len_m + 1;
      for (int i = 0; i < MAXD; i++) begin
         dec_halt[i] = ($urandom_range(0, 15) == 0);
         dec_br[i]   = ($urandom_range(0, 3) == 0);
         dec_tgt[i]  = ADDR_W'($urandom_range(0, hi));
      end
      dec_halt[23] = 1'b1;
   endtask

   task automatic apply_dec(input int k);
      branch_taken  = dec_br[k];
      halt          = dec_halt[k];
      branch_target = dec_tgt[k];
   endtask

   // Executes the decision list on the program model, then drives the DUT through the same run.
   task automatic run_prog(input bit lat, input bit rnd);
      int pcm, nxt, nsteps, k, c;
      int hs_cyc [MAXD];
      bit hs;
      pcm = 0;
      nsteps = 0;
      forever begin
         exp_ix_q.push_back({ADDR_W'(pcm), prog_model[pcm]});
         nsteps++;
         if (dec_halt[nsteps-1]) break;
         nxt = dec_br[nsteps-1] ? int'(dec_tgt[nsteps-1]) : pcm + 1;
         if (nxt >= len_m) break;
         pcm = nxt;
      end
      k = 0;
      c = 0;
      apply_dec(0);
      clk_enable  = 1'b1;
      instr_ready = 1'b1;
      run         = 1'b1;
      for (int it = 0; it < 4000; it++) begin
         @(negedge clk);
         c++;
         hs = clk_enable & instr_valid & instr_ready;
         if (hs) hs_cyc[k] = c;
         step();
         if (hs) k++;
         if (k == nsteps) break;
         apply_dec(k);
         if (rnd) begin
            clk_enable  = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
         end
      end
      check("run_handshake_count", 32'(k), 32'(nsteps));
      if (lat && k == nsteps) begin
         check("first_valid_latency", 32'(hs_cyc[0]), 32'd4);
         for (int j = 1; j < nsteps; j++)
            check("issue_spacing", 32'(hs_cyc[j] - hs_cyc[j-1]), 32'd3);
      end
      branch_taken = 1'b0;
      halt         = 1'b0;
      clk_enable   = 1'b1;
      instr_ready  = 1'b1;
      repeat (3) step();
      check("halt_pc", 32'(pc), 32'(pcm));
      check("halt_valid", 32'(instr_valid), 32'd0);
      run = 1'b0;
      step();
      check("stop_pc", 32'(pc), 32'd0);
      check("stop_valid", 32'(instr_valid), 32'd0);
      check("stop_prog_len", 32'(prog_len), 32'(len_m));
      instr_ready = 1'b0;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20; i++) begin
         if (instr_valid) break;
         step();
      end
      check("valid_wait", 32'(instr_valid), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
      check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_raddr"}, 32'(mem_raddr), 32'd0);
      check({tag, "_instr_out"}, 32'(instr_out), 32'd0);
      check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_pc"}, 32'(pc), 32'd0);
      check({tag, "_prog_len"}, 32'(prog_len), 32'd0);
      check({tag, "_load_full"}, 32'(load_full), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DATA_W-1:0] saved;
      reset = 1'b1; clk_enable = 1'b1; button = 1'b0; instruction = '0; run = 1'b0;
      branch_taken = 1'b0; branch_target = '0; halt = 1'b0; instr_ready = 1'b0;
      repeat (3) step();
      check_all_zero("reset");
      reset = 1'b0;
      step();

      // Directed word 0x0453 at address 0.
      load_word(8'h01, 8'h05, 8'h03, 1'b0);
      check("word_0453", 32'(mem[0]), 32'h0453);

      // An edge during disabled cycles must not advance the entry phase.
      clk_enable = 1'b0; button = 1'b1; instruction = 8'h3f;
      repeat (2) step();
      button = 1'b0;
      step();
      clk_enable = 1'b1;
      step();
      load_random(1'b1);
      load_random(1'b1);

      // Three-word program runs straight through with full-speed latency checks.
      clear_dec();
      run_prog(1'b1, 1'b0);

      // Branch back to 0, then branch past the end.
      clear_dec();
      dec_br[1] = 1'b1; dec_tgt[1] = 6'd0;
      dec_br[3] = 1'b1; dec_tgt[3] = 6'd5;
      run_prog(1'b0, 1'b0);

      // Stall in ISSUE at pc 1, then drop run.
      clear_dec();
      apply_dec(0);
      instr_ready = 1'b0; clk_enable = 1'b1; run = 1'b1;
      wait_valid();
      exp_ix_q.push_back({ADDR_W'(0), prog_model[0]});
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      wait_valid();
      check("stall_pc", 32'(pc), 32'd1);
      saved = instr_out;
      check("stall_instr", 32'(instr_out), 32'(prog_model[1]));
      repeat (4) begin
         step();
         check("stall_hold_data", 32'(instr_out), 32'(saved));
         check("stall_hold_valid", 32'(instr_valid), 32'd1);
      end
      run = 1'b0;
      step();
      check("drop_valid", 32'(instr_valid), 32'd0);
      check("drop_pc", 32'(pc), 32'd0);
      check("drop_prog_len", 32'(prog_len), 32'(len_m));

      // Partial word is discarded when run rises.
      press(8'h2a, 1'b0);
      press(8'h15, 1'b0);
      run = 1'b1;
      repeat (5) step();
      run = 1'b0;
      step();
      load_random(1'b0);

      for (int r = 0; r < 4; r++) begin
         load_random(1'b1);
         gen_dec();
         run_prog(1'b0, 1'b1);
      end

      // Reset in the middle of a run.
      clear_dec();
      apply_dec(0);
      instr_ready = 1'b0; clk_enable = 1'b1; run = 1'b1;
      wait_valid();
      reset = 1'b1;
      step();
      check_all_zero("midrun_reset");
      reset = 1'b0;
      run = 1'b0;
      len_m = 0;
      step();

      // run with an empty program stays in LOAD and ignores buttons.
      run = 1'b1;
      press(8'h11, 1'b0);
      press(8'h22, 1'b0);
      press(8'h33, 1'b0);
      step();
      check("empty_run_valid", 32'(instr_valid), 32'd0);
      check("empty_run_len", 32'(prog_len), 32'd0);
      run = 1'b0;
      step();

      // Fill memory, then one triple beyond full.
      for (int i = 0; i < DEPTH; i++) load_random(1'b1);
      check("full_flag", 32'(load_full), 32'd1);
      load_random(1'b1);
      check("full_len", 32'(prog_len), 32'd64);
      check("full_flag_after", 32'(load_full), 32'd1);

      clear_dec();
      run_prog(1'b0, 1'b1);
      gen_dec();
      run_prog(1'b0, 1'b1);

      repeat (3) step();
      check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
      check("ix_queue_empty", 32'(exp_ix_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
